// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V core front end.
// Fetch-queue entries pair each instruction word with the PC it was fetched from.
package riscv_pkg;

    localparam int PC_W        = 16;
    localparam int INSTR_W     = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 16'h0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instruction;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = INSTR_W + PC_W;

    // Fetch addresses are always word aligned.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush; pointers carry an extra wrap bit so
// full and empty are distinguishable without a separate counter.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head_data = mem[rd_ptr[AW-1:0]];
    assign empty     = (wr_ptr == rd_ptr);
    assign count     = wr_ptr - rd_ptr;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, credit-limited request issue to
// instruction memory, and an in-order queue of returned words for decode.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [15:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [15:0] instr_pc,
    input  logic        instr_ready,
    output logic [15:0] pc,
    output logic [15:0] pc_next
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          redirect_d;
    logic [CW-1:0] in_flight;
    logic [CW-1:0] squash;
    logic [CW-1:0] in_flight_after;
    logic [CW-1:0] squash_after;
    logic [CW:0]   occupancy;

    logic req_fire;
    logic resp_live;
    logic resp_drop;
    logic resp_push;
    logic instr_pop;

    logic [FETCH_ENTRY_W-1:0] q_head;
    logic                     q_empty;
    logic [CW-1:0]            q_count;
    fetch_entry_t             push_entry;
    fetch_entry_t             head_entry;

    logic [PC_W-1:0] shadow_head;
    logic            shadow_empty;
    logic [CW-1:0]   shadow_count;

    // The shadow FIFO holds every outstanding address, squashed or not, so
    // its occupancy equals in-flight plus squash.
    assign occupancy      = {1'b0, shadow_count} + {1'b0, q_count};
    assign imem_req_valid = !rst && !redirect_d && (occupancy < (CW+1)'(DEPTH));
    assign imem_addr      = pc;

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign resp_live = imem_resp_valid && !shadow_empty;
    assign resp_drop = resp_live && (squash != '0);
    assign resp_push = resp_live && (squash == '0);
    assign instr_pop = instr_valid && instr_ready;

    assign pc_next = redirect_valid ? align_pc(redirect_pc) : pc + PC_W'(INSTR_BYTES);

    always_comb begin
        in_flight_after = in_flight + CW'(req_fire) - CW'(resp_push);
        squash_after    = squash - CW'(resp_drop);
    end

    // On redirect every request still owed a response becomes squashed,
    // including one accepted in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            redirect_d <= 1'b0;
            in_flight  <= '0;
            squash     <= '0;
        end else begin
            redirect_d <= redirect_valid;
            if (redirect_valid || req_fire) pc <= pc_next;
            if (redirect_valid) begin
                squash    <= squash_after + in_flight_after;
                in_flight <= '0;
            end else begin
                squash    <= squash_after;
                in_flight <= in_flight_after;
            end
        end
    end

    assign push_entry = '{instruction: imem_rdata, pc: shadow_head};

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (FETCH_ENTRY_W)
    ) u_instr_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (resp_push),
        .pop       (instr_pop),
        .push_data (push_entry),
        .head_data (q_head),
        .empty     (q_empty),
        .count     (q_count)
    );

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (PC_W)
    ) u_addr_shadow (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (req_fire),
        .pop       (resp_live),
        .push_data (pc),
        .head_data (shadow_head),
        .empty     (shadow_empty),
        .count     (shadow_count)
    );

    assign head_entry  = q_head;
    assign instr_valid = !rst && !q_empty;
    assign instruction = head_entry.instruction;
    assign instr_pc    = head_entry.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a latency-programmable memory responder
// and a decode-side order checker run alongside the main step sequence.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [15:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [15:0] instr_pc;
    logic        instr_ready = 1'b1;
    logic [15:0] pc;
    logic [15:0] pc_next;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] exp_pc    = 16'h0000;
    logic [15:0] issue_exp = 16'h0000;
    int          mem_lat   = 1;
    logic [15:0] pend_addr[$];
    int          pend_due[$];

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC (16'h0000),
        .DEPTH    (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .instr_valid     (instr_valid),
        .instruction     (instruction),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready),
        .pc              (pc),
        .pc_next         (pc_next)
    );

    function automatic logic [31:0] wordFor(input logic [15:0] addr);
        return {~addr, addr};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic mem_rdy, input logic dec_rdy,
                                 input logic rv, input logic [15:0] rpc);
        @(negedge clk);
        rst            = r;
        imem_req_ready = mem_rdy;
        instr_ready    = dec_rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #2;
    endtask

    // Returns one word per accepted request, in order, mem_lat cycles later.
    task automatic runMemory();
        int cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_rdata      = wordFor(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                imem_resp_valid = 1'b0;
                imem_rdata      = '0;
            end
            #1;
            if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) begin
                checkOutput("imem_addr_seq", imem_addr, issue_exp);
                issue_exp = issue_exp + 16'd4;
                pend_addr.push_back(imem_addr);
                pend_due.push_back(cyc + mem_lat);
            end
        end
    endtask

    task automatic watchDecode();
        forever begin
            @(negedge clk);
            #3;
            if (!rst && !redirect_valid && instr_valid === 1'b1 && instr_ready) begin
                checkOutput("instr_pc_order", instr_pc, exp_pc);
                checkOutput("instruction_word", instruction, wordFor(exp_pc));
                exp_pc = exp_pc + 16'd4;
            end
        end
    endtask

    task automatic drainAndCheck(input string tag);
        repeat (8) applyStimulus(0, 0, 1, 0, 16'h0000);
        checkOutput({tag, "_empty"}, instr_valid, 1'b0);
        checkOutput({tag, "_pc_caught_up"}, pc, exp_pc);
    endtask

    initial begin
        fork
            runMemory();
            watchDecode();
        join_none

        // Reset state
        applyStimulus(1, 1, 1, 0, 16'h0000);
        checkOutput("rst_req_valid", imem_req_valid, 1'b0);
        checkOutput("rst_instr_valid", instr_valid, 1'b0);
        checkOutput("rst_pc", pc, 16'h0000);
        checkOutput("rst_pc_next", pc_next, 16'h0004);

        // Streaming with 1-cycle memory and an always-ready decode
        applyStimulus(0, 1, 1, 0, 16'h0000);
        checkOutput("c0_req_valid", imem_req_valid, 1'b1);
        checkOutput("c0_addr", imem_addr, 16'h0000);
        checkOutput("c0_instr_valid", instr_valid, 1'b0);
        applyStimulus(0, 1, 1, 0, 16'h0000);
        checkOutput("c1_addr", imem_addr, 16'h0004);
        checkOutput("c1_pc_next", pc_next, 16'h0008);
        checkOutput("c1_instr_valid", instr_valid, 1'b0);
        applyStimulus(0, 1, 1, 0, 16'h0000);
        checkOutput("c2_req_credit_block", imem_req_valid, 1'b0);
        checkOutput("c2_instr_valid", instr_valid, 1'b1);
        checkOutput("c2_instr_pc", instr_pc, 16'h0000);
        checkOutput("c2_instruction", instruction, 32'hFFFF_0000);
        applyStimulus(0, 1, 1, 0, 16'h0000);
        checkOutput("c3_req_valid", imem_req_valid, 1'b1);
        checkOutput("c3_addr", imem_addr, 16'h0008);
        checkOutput("c3_instr_pc", instr_pc, 16'h0004);
        repeat (8) applyStimulus(0, 1, 1, 0, 16'h0000);
        drainAndCheck("stream");

        // Request held while memory is not ready
        checkOutput("hold_req_valid", imem_req_valid, 1'b1);
        checkOutput("hold_addr0", imem_addr, exp_pc);
        applyStimulus(0, 0, 1, 0, 16'h0000);
        checkOutput("hold_addr1", imem_addr, exp_pc);

        // Decode stall: credits run out, nothing consumed
        repeat (5) applyStimulus(0, 1, 0, 0, 16'h0000);
        checkOutput("stall_req_valid", imem_req_valid, 1'b0);
        checkOutput("stall_instr_valid", instr_valid, 1'b1);
        checkOutput("stall_head_pc", instr_pc, exp_pc);

        // Memory ready toggling
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, (i % 2 == 0), 1, 0, 16'h0000);
            if ((i % 2 != 0) && imem_req_valid) checkOutput("toggle_addr_stable", imem_addr, issue_exp);
        end
        drainAndCheck("toggle");

        // Redirect with two requests in flight
        mem_lat = 3;
        applyStimulus(0, 1, 1, 0, 16'h0000);
        checkOutput("redir_pre_req0", imem_req_valid, 1'b1);
        applyStimulus(0, 1, 1, 0, 16'h0000);
        checkOutput("redir_pre_req1", imem_req_valid, 1'b1);
        applyStimulus(0, 1, 1, 1, 16'h0102);
        exp_pc    = 16'h0100;
        issue_exp = 16'h0100;
        checkOutput("redir_req_full", imem_req_valid, 1'b0);
        checkOutput("redir_pc_next", pc_next, 16'h0100);
        applyStimulus(0, 1, 1, 0, 16'h0000);
        checkOutput("redir_pc", pc, 16'h0100);
        checkOutput("redir_bubble", imem_req_valid, 1'b0);
        checkOutput("redir_instr_valid", instr_valid, 1'b0);
        applyStimulus(0, 1, 1, 0, 16'h0000);
        checkOutput("redir_resume_valid", imem_req_valid, 1'b1);
        checkOutput("redir_resume_addr", imem_addr, 16'h0100);
        repeat (6) applyStimulus(0, 1, 1, 0, 16'h0000);
        drainAndCheck("redirect");

        // PC wrap at the top of the address space
        mem_lat = 1;
        applyStimulus(0, 0, 1, 1, 16'hFFFE);
        exp_pc    = 16'hFFFC;
        issue_exp = 16'hFFFC;
        checkOutput("wrap_pc_next_align", pc_next, 16'hFFFC);
        applyStimulus(0, 1, 1, 0, 16'h0000);
        checkOutput("wrap_pc", pc, 16'hFFFC);
        checkOutput("wrap_bubble", imem_req_valid, 1'b0);
        checkOutput("wrap_pc_next", pc_next, 16'h0000);
        applyStimulus(0, 1, 1, 0, 16'h0000);
        checkOutput("wrap_addr_top", imem_addr, 16'hFFFC);
        applyStimulus(0, 1, 1, 0, 16'h0000);
        checkOutput("wrap_addr_zero", imem_addr, 16'h0000);
        checkOutput("wrap_req_valid", imem_req_valid, 1'b1);
        repeat (4) applyStimulus(0, 1, 1, 0, 16'h0000);
        drainAndCheck("wrap");

        // Reset mid-stream with a response still pending
        mem_lat = 3;
        applyStimulus(0, 1, 0, 0, 16'h0000);
        mem_lat = 5;
        applyStimulus(0, 1, 0, 0, 16'h0000);
        applyStimulus(0, 0, 0, 0, 16'h0000);
        applyStimulus(0, 0, 0, 0, 16'h0000);
        applyStimulus(1, 0, 0, 0, 16'h0000);
        checkOutput("mrst_instr_valid", instr_valid, 1'b0);
        checkOutput("mrst_req_valid", imem_req_valid, 1'b0);
        applyStimulus(1, 0, 0, 1, 16'h0200);
        checkOutput("mrst_pc", pc, 16'h0000);
        checkOutput("mrst_queue_empty", instr_valid, 1'b0);
        applyStimulus(0, 0, 1, 0, 16'h0000);
        exp_pc    = 16'h0000;
        issue_exp = 16'h0000;
        checkOutput("mrst_reset_wins_pc", pc, 16'h0000);
        checkOutput("mrst_no_bubble", imem_req_valid, 1'b1);
        checkOutput("mrst_addr", imem_addr, 16'h0000);
        applyStimulus(0, 0, 1, 0, 16'h0000);
        checkOutput("mrst_stale_ignored", instr_valid, 1'b0);
        mem_lat = 1;
        repeat (6) applyStimulus(0, 1, 1, 0, 16'h0000);
        drainAndCheck("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
